// File: rtl/alu_seq.sv
// Multi-cycle ALU: 1-cycle add/sub/logic, iterative shifts (1 bit/cycle) and shift-add multiply.
// Latency 1 / max(k,1) / nBit cycles; start is ignored while busy, and a start in the done cycle is accepted.
module alu_seq #(
    parameter int nBit   = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      FS,
    input  logic [nBit-1:0] A,
    input  logic [nBit-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [nBit-1:0] out,
    output logic            zero_flag,
    output logic            carry_flag,
    output logic            neg_flag,
    output logic            ovf_flag
);
    localparam int KW = $clog2(nBit);
    localparam int CW = KW + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t              state, state_nxt;
    logic [nBit-1:0]     sh_reg, sh_nxt;
    logic [1:0]          sh_op, sh_op_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [2*nBit-1:0]   acc, acc_nxt, mcand, mcand_nxt;
    logic [nBit-1:0]     mplier, mplier_nxt;

    logic                fin, fin_c, fin_v, fin_z, is_add;
    logic [nBit-1:0]     fin_res;
    logic [nBit:0]       sum, diff, s1, sw;
    logic [2*nBit-1:0]   acc_add;
    logic [KW-1:0]       k;

    // One shift step: {bit shifted out, shifted value}; op 00 SLL, 01 SRL, 10 SRA
    function automatic logic [nBit:0] shift1(input logic [nBit-1:0] v, input logic [1:0] op);
        case (op)
            2'b01:   shift1 = {v[0], 1'b0, v[nBit-1:1]};
            2'b10:   shift1 = {v[0], v[nBit-1], v[nBit-1:1]};
            default: shift1 = {v[nBit-1], v[nBit-2:0], 1'b0};
        endcase
    endfunction

    assign sum     = {1'b0, A} + {1'b0, B};
    assign diff    = {1'b0, A} - {1'b0, B};
    assign k       = B[KW-1:0];
    assign s1      = shift1(A, FS[1:0]);
    assign sw      = shift1(sh_reg, sh_op);
    assign acc_add = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            out        <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
            sh_reg     <= '0;
            sh_op      <= '0;
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
        end else begin
            state  <= state_nxt;
            done   <= fin;
            sh_reg <= sh_nxt;
            sh_op  <= sh_op_nxt;
            cnt    <= cnt_nxt;
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            if (fin) begin
                out        <= fin_res;
                zero_flag  <= fin_z;
                carry_flag <= fin_c;
                ovf_flag   <= fin_v;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        fin        = 1'b0;
        fin_res    = '0;
        fin_c      = 1'b0;
        fin_v      = 1'b0;
        is_add     = 1'b0;
        sh_nxt     = sh_reg;
        sh_op_nxt  = sh_op;
        cnt_nxt    = cnt;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        case (state)
            IDLE: if (start) begin
                fin = 1'b1;
                case (FS)
                    4'b0000: begin
                        {fin_c, fin_res} = sum;
                        fin_v  = (A[nBit-1] == B[nBit-1]) && (sum[nBit-1] != A[nBit-1]);
                        is_add = 1'b1;
                    end
                    4'b0001: begin
                        fin_res = diff[nBit-1:0];
                        fin_c   = ~diff[nBit];
                        fin_v   = (A[nBit-1] != B[nBit-1]) && (diff[nBit-1] != A[nBit-1]);
                    end
                    4'b0010, 4'b0110: fin_res = A & B;
                    4'b0011, 4'b0111: fin_res = A | B;
                    4'b0100:          fin_res = A ^ B;
                    4'b0101:          fin_res = ~A;
                    4'b1000, 4'b1001, 4'b1010: begin
                        if (k == '0) begin
                            fin_res = A;
                        end else if (k == KW'(1)) begin
                            {fin_c, fin_res} = s1;
                        end else begin
                            // First step happens at capture so the last lands k-1 edges later
                            fin       = 1'b0;
                            state_nxt = SHIFT;
                            sh_nxt    = s1[nBit-1:0];
                            sh_op_nxt = FS[1:0];
                            cnt_nxt   = CW'(k) - CW'(1);
                        end
                    end
                    4'b1011: if (MUL_EN) begin
                        fin        = 1'b0;
                        state_nxt  = MUL;
                        acc_nxt    = B[0] ? {{nBit{1'b0}}, A} : '0;
                        mcand_nxt  = {{(nBit-1){1'b0}}, A, 1'b0};
                        mplier_nxt = B >> 1;
                        cnt_nxt    = CW'(nBit - 1);
                    end
                    default: fin_res = '0;
                endcase
            end
            SHIFT: begin
                sh_nxt  = sw[nBit-1:0];
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    fin              = 1'b1;
                    state_nxt        = IDLE;
                    {fin_c, fin_res} = sw;
                end
            end
            MUL: begin
                acc_nxt    = acc_add;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                    fin_res   = acc_add[nBit-1:0];
                    fin_v     = |acc_add[2*nBit-1:nBit];
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Add reports zero only when the full nBit+1 result is zero
        fin_z = (fin_res == '0) && !(is_add && fin_c);
    end

    assign busy     = (state != IDLE);
    assign neg_flag = out[nBit-1];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (nBit=16): results, flags, latency, busy/done timing, reset abort.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  FS;
    logic [15:0] A, B;
    logic        busy, done;
    logic [15:0] out;
    logic        zero_flag, carry_flag, neg_flag, ovf_flag;
    logic [3:0]  nzcv;

    int checks = 0;
    int errors = 0;

    alu_seq #(.nBit(16), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .FS(FS), .A(A), .B(B),
        .busy(busy), .done(done), .out(out), .zero_flag(zero_flag),
        .carry_flag(carry_flag), .neg_flag(neg_flag), .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;
    assign nzcv = {neg_flag, zero_flag, carry_flag, ovf_flag};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; start is held for exactly one cycle
    task automatic issue(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b);
        start = 1'b1; FS = fs; A = a; B = b;
        @(negedge clk);
        start = 1'b0; FS = 4'($urandom); A = 16'($urandom); B = 16'($urandom);
    endtask

    task automatic wait_done(input string tag, input int poke_at, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 64) begin
            chk({tag, "_busy_mid"}, {31'b0, busy}, 32'd1);
            if (cyc == poke_at) begin
                start = 1'b1; FS = 4'b0000; A = 16'h0001; B = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic check_res(input string tag, input int cyc, input int lat,
                             input logic [15:0] eo, input logic [3:0] ef);
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        chk({tag, "_out"}, {16'b0, out}, {16'b0, eo});
        chk({tag, "_nzcv"}, {28'b0, nzcv}, {28'b0, ef});
    endtask

    task automatic do_op(input string tag, input logic [3:0] fs, input logic [15:0] a,
                         input logic [15:0] b, input int lat, input logic [15:0] eo,
                         input logic [3:0] ef);
        int cyc;
        @(negedge clk);
        chk({tag, "_idle_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        issue(fs, a, b);
        wait_done(tag, 0, cyc);
        check_res(tag, cyc, lat, eo, ef);
    endtask

    initial begin
        int cyc;
        int n;
        rst = 1'b1; start = 1'b0; FS = 4'h0; A = 16'h0; B = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_out", {16'b0, out}, 32'd0);
        chk("rst_nzcv", {28'b0, nzcv}, 32'd0);

        // flags order: N Z C V
        do_op("add_wrap", 4'b0000, 16'hFFFF, 16'h0001, 1, 16'h0000, 4'b0010);
        do_op("add_ovf",  4'b0000, 16'h7FFF, 16'h0001, 1, 16'h8000, 4'b1001);
        do_op("sub_eq",   4'b0001, 16'h1234, 16'h1234, 1, 16'h0000, 4'b0110);
        do_op("sub_brw",  4'b0001, 16'h0000, 16'h0001, 1, 16'hFFFF, 4'b1000);
        do_op("and",      4'b0010, 16'hF0F0, 16'h0FF0, 1, 16'h00F0, 4'b0000);
        do_op("and_alt",  4'b0110, 16'hF0F0, 16'h0FF0, 1, 16'h00F0, 4'b0000);
        do_op("or",       4'b0011, 16'hF0F0, 16'h0FF0, 1, 16'hFFF0, 4'b1000);
        do_op("or_alt",   4'b0111, 16'hF0F0, 16'h0FF0, 1, 16'hFFF0, 4'b1000);
        do_op("xor",      4'b0100, 16'hF0F0, 16'h0FF0, 1, 16'hFF00, 4'b1000);
        do_op("not",      4'b0101, 16'hF0F0, 16'h0FF0, 1, 16'h0F0F, 4'b0000);
        do_op("sra3",     4'b1010, 16'h8000, 16'h0003, 3, 16'hF000, 4'b1000);
        do_op("sra2_pos", 4'b1010, 16'h7000, 16'h0002, 2, 16'h1C00, 4'b0000);
        do_op("sll1",     4'b1000, 16'h8001, 16'h0001, 1, 16'h0002, 4'b0010);
        do_op("sll0",     4'b1000, 16'h8001, 16'h0010, 1, 16'h8001, 4'b1000);
        do_op("srl4",     4'b1001, 16'h000F, 16'h0004, 4, 16'h0000, 4'b0110);
        do_op("mul",      4'b1011, 16'h00FF, 16'h0003, 16, 16'h02FD, 4'b0000);
        do_op("mul_hi",   4'b1011, 16'h0100, 16'h0100, 16, 16'h0000, 4'b0101);
        do_op("rsvd",     4'b1100, 16'h0005, 16'h0005, 1, 16'h0000, 4'b0100);

        // start pulsed mid-MUL is ignored; then two back-to-back issues in done cycles
        @(negedge clk);
        issue(4'b1011, 16'h00FF, 16'h0003);
        wait_done("mul_poke", 4, cyc);
        check_res("mul_poke", cyc, 16, 16'h02FD, 4'b0000);
        issue(4'b1010, 16'h8000, 16'h0003);
        wait_done("b2b_sra", 0, cyc);
        check_res("b2b_sra", cyc, 3, 16'hF000, 4'b1000);
        issue(4'b0000, 16'h0001, 16'h0002);
        wait_done("b2b_add", 0, cyc);
        check_res("b2b_add", cyc, 1, 16'h0003, 4'b0000);

        // reset in cycle 5 of a MUL discards it
        do_op("pre_rst", 4'b0001, 16'h0000, 16'h0001, 1, 16'hFFFF, 4'b1000);
        @(negedge clk);
        issue(4'b1011, 16'h00FF, 16'h0003);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_out", {16'b0, out}, 32'd0);
        chk("abort_nzcv", {28'b0, nzcv}, 32'd0);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        chk("abort_no_done", n, 0);
        do_op("post_rst", 4'b0000, 16'h1111, 16'h2222, 1, 16'h3333, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
